// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl
//   Forwarding and load-use hazard control for a 5-stage IF/ID/EX/MEM/WB
//   pipeline. Keeps destination tags for the instructions in EX and MEM and
//   decides, for the instruction currently in ID, where each EX operand will
//   come from once that instruction reaches EX. A load followed directly by
//   a consumer of its result costs one stall cycle and one EX bubble.
//
// Ports
//   clk, reset_n              pipeline clock, synchronous active-low reset
//   id_valid                  ID holds a real instruction
//   id_rn/id_rm               ID source register indices
//   id_rn_used/id_rm_used     source is actually read
//   id_rd, id_wr_en           ID destination and its write enable
//   id_is_load                ID instruction is a load
//   flush                     taken branch: kill ID and EX
//   stall                     combinational; hold PC and IF/ID
//   fwd_a_sel/fwd_b_sel       registered operand source in EX:
//                             00 regfile, 01 EX/MEM, 10 MEM/WB
//   ex_bubble                 registered; EX holds no instruction

// Per-source tag comparison against the two in-flight slots.
module fwd_src_match #(
  parameter int REG_BITS = 4,
  parameter int PC_REG   = 15
) (
  input  logic [REG_BITS-1:0] src,
  input  logic                used,
  input  logic                ex_valid,
  input  logic                ex_wr,
  input  logic [REG_BITS-1:0] ex_rd,
  input  logic                mem_valid,
  input  logic                mem_wr,
  input  logic [REG_BITS-1:0] mem_rd,
  output logic                ex_hit,
  output logic                mem_hit
);
  logic fwdable;

  // The PC register is supplied by its own path and is never forwarded.
  assign fwdable = used & (src != REG_BITS'(PC_REG));
  assign ex_hit  = fwdable & ex_valid  & ex_wr  & (ex_rd  == src);
  assign mem_hit = fwdable & mem_valid & mem_wr & (mem_rd == src);
endmodule

module fwd_hazard_ctrl #(
  parameter int REG_BITS = 4,
  parameter int PC_REG   = 15
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rn,
  input  logic [REG_BITS-1:0] id_rm,
  input  logic                id_rn_used,
  input  logic                id_rm_used,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic                id_wr_en,
  input  logic                id_is_load,
  input  logic                flush,
  output logic                stall,
  output logic [1:0]          fwd_a_sel,
  output logic [1:0]          fwd_b_sel,
  output logic                ex_bubble
);
  localparam int NSRC = 2;

  typedef struct packed {
    logic                valid;
    logic [REG_BITS-1:0] rd;
    logic                wr_en;
    logic                is_load;
  } tag_t;

  tag_t ex_q, mem_q;

  logic [NSRC-1:0][REG_BITS-1:0] src;
  logic [NSRC-1:0]               used;
  logic [NSRC-1:0]               ex_hit, mem_hit;
  logic [NSRC-1:0][1:0]          sel_nxt, sel_q;
  logic                          take_id;

  assign src  = {id_rm, id_rn};
  assign used = {id_rm_used, id_rn_used};

  // Sources are compared only against older tags, so an instruction that
  // reads and writes the same register never matches itself.
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    fwd_src_match #(.REG_BITS(REG_BITS), .PC_REG(PC_REG)) u_match (
      .src      (src[i]),
      .used     (used[i]),
      .ex_valid (ex_q.valid),
      .ex_wr    (ex_q.wr_en),
      .ex_rd    (ex_q.rd),
      .mem_valid(mem_q.valid),
      .mem_wr   (mem_q.wr_en),
      .mem_rd   (mem_q.rd),
      .ex_hit   (ex_hit[i]),
      .mem_hit  (mem_hit[i])
    );
    // EX producer moves to MEM next cycle (01); MEM producer to WB (10).
    // The EX match is the newer value and wins.
    assign sel_nxt[i] = ex_hit[i]  ? 2'b01 :
                        mem_hit[i] ? 2'b10 : 2'b00;
  end

  // Load result is not ready until after MEM: one cycle of hold.
  // Depends only on slot state and ID inputs, never on the select registers.
  assign stall   = id_valid & ~flush & ex_q.is_load & (|ex_hit);
  assign take_id = id_valid & ~flush & ~stall;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_q      <= '0;
      mem_q     <= '0;
      sel_q     <= '0;
      ex_bubble <= 1'b1;
    end else begin
      // MEM always advances, including from an EX slot being flushed.
      mem_q <= ex_q;
      if (take_id) begin
        ex_q      <= '{valid: 1'b1, rd: id_rd, wr_en: id_wr_en, is_load: id_is_load};
        sel_q     <= sel_nxt;
        ex_bubble <= 1'b0;
      end else begin
        ex_q      <= '0;
        sel_q     <= '0;
        ex_bubble <= 1'b1;
      end
    end
  end

  assign fwd_a_sel = sel_q[0];
  assign fwd_b_sel = sel_q[1];
endmodule
